// File: rtl/case_9_pkg.sv
// Shared types and width helpers for the case_9 product accumulator.
package case_9_pkg;

   typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Accumulator holds MAX_LEN worst-case terms without overflow.
   function automatic int acc_w(input int din_w, input int max_len);
      return din_w + clog2(max_len);
   endfunction

   function automatic int cnt_w(input int max_len);
      return clog2(max_len) + 1;
   endfunction

   function automatic longint sat_hi(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   function automatic longint sat_lo(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/case_9_prod_acc_narrow.sv
// Narrows the wide group sum to DOUT_WIDTH and flags out-of-range sums.
// CASE_9_PROD_ACC_SAT_EN selects clamping; otherwise two's-complement wrap.
module case_9_prod_acc_narrow
   import case_9_pkg::*;
#(
   parameter int ACC_W      = 23,
   parameter int DOUT_WIDTH = 20
) (
   input  logic signed [ACC_W-1:0]      sum,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         ovf
);

   localparam logic signed [DOUT_WIDTH-1:0] HI = DOUT_WIDTH'(sat_hi(DOUT_WIDTH));
   localparam logic signed [DOUT_WIDTH-1:0] LO = DOUT_WIDTH'(sat_lo(DOUT_WIDTH));

   // In range exactly when all bits above the result sign bit match it.
   logic [ACC_W-DOUT_WIDTH:0] top;
   assign top = sum[ACC_W-1:DOUT_WIDTH-1];
   assign ovf = !((&top) || (~|top));

`ifdef CASE_9_PROD_ACC_SAT_EN
   always_comb begin
      dout = sum[DOUT_WIDTH-1:0];
      if (ovf) dout = sum[ACC_W-1] ? LO : HI;
   end
`else
   assign dout = sum[DOUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/case_9_prod_acc.sv
// Group accumulator for signed products: sums until din_last or MAX_LEN terms,
// then holds the narrowed result until taken (see CASE_9_PROD_ACC_SAT_EN in narrow).
module case_9_prod_acc
   import case_9_pkg::*;
#(
   parameter int DIN_WIDTH  = 17,
   parameter int DOUT_WIDTH = 20,
   parameter int MAX_LEN    = 64,
   parameter int CNT_WIDTH  = 7
) (
   input  logic                         ap_clk,
   input  logic                         ap_rst,
   input  logic signed [DIN_WIDTH-1:0]  din,
   input  logic                         din_valid,
   input  logic                         din_last,
   output logic                         din_ready,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic [CNT_WIDTH-1:0]         dout_len,
   output logic                         dout_ovf,
   output logic                         dout_valid,
   input  logic                         dout_ready
);

   localparam int ACC_W = acc_w(DIN_WIDTH, MAX_LEN);

   state_t                    state, state_nxt;
   logic signed [ACC_W-1:0]   acc, acc_nxt;
   logic [CNT_WIDTH-1:0]      cnt, cnt_nxt;
   logic signed [DOUT_WIDTH-1:0] nar_dout;
   logic                      nar_ovf;
   logic                      xfer, close;

   assign din_ready  = (state == ST_ACC);
   assign dout_valid = (state == ST_HOLD);
   assign xfer       = din_valid & din_ready;
   assign acc_nxt    = acc + {{(ACC_W-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
   assign cnt_nxt    = cnt + CNT_WIDTH'(1);
   // Both close reasons share one flush.
   assign close      = din_last | (cnt_nxt == CNT_WIDTH'(MAX_LEN));

   case_9_prod_acc_narrow #(
      .ACC_W      (ACC_W),
      .DOUT_WIDTH (DOUT_WIDTH)
   ) u_narrow (
      .sum  (acc_nxt),
      .dout (nar_dout),
      .ovf  (nar_ovf)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) state <= ST_ACC;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ACC:  if (xfer && close) state_nxt = ST_HOLD;
         ST_HOLD: if (dout_ready)    state_nxt = ST_ACC;
         default: state_nxt = ST_ACC;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         acc      <= '0;
         cnt      <= '0;
         dout     <= '0;
         dout_len <= '0;
         dout_ovf <= 1'b0;
      end else if (xfer) begin
         if (close) begin
            acc      <= '0;
            cnt      <= '0;
            dout     <= nar_dout;
            dout_len <= cnt_nxt;
            dout_ovf <= nar_ovf;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
         end
      end
   end

endmodule

// File: tb/tb_case_9_prod_acc.sv
// Directed bench for case_9_prod_acc; expected values follow the build's
// CASE_9_PROD_ACC_SAT_EN setting.
module tb_case_9_prod_acc;

   logic               ap_clk = 1'b0;
   logic               ap_rst = 1'b1;
   logic signed [16:0] din = '0;
   logic               din_valid = 1'b0;
   logic               din_last = 1'b0;
   logic               din_ready;
   logic signed [19:0] dout;
   logic [6:0]         dout_len;
   logic               dout_ovf;
   logic               dout_valid;
   logic               dout_ready = 1'b0;

   int tests = 0;
   int fails = 0;

   case_9_prod_acc dut (
      .ap_clk     (ap_clk),
      .ap_rst     (ap_rst),
      .din        (din),
      .din_valid  (din_valid),
      .din_last   (din_last),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_len   (dout_len),
      .dout_ovf   (dout_ovf),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input longint v, input bit last);
      int n;
      @(negedge ap_clk);
      din = 17'(v); din_valid = 1'b1; din_last = last;
      n = 0;
      while (!din_ready && n < 50) begin @(negedge ap_clk); n++; end
      if (n >= 50) chk("send_timeout", longint'(din_ready), 1);
      @(posedge ap_clk); #1;
      din_valid = 1'b0; din_last = 1'b0;
   endtask

   task automatic take();
      int n;
      @(negedge ap_clk);
      dout_ready = 1'b1;
      n = 0;
      while (!dout_valid && n < 50) begin @(negedge ap_clk); n++; end
      if (n >= 50) chk("take_timeout", longint'(dout_valid), 1);
      @(posedge ap_clk); #1;
      dout_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      #12;
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_din_ready", din_ready, 1);
      chk("rst_dout", dout, 0);
      chk("rst_len", dout_len, 0);
      @(negedge ap_clk); ap_rst = 1'b0;

      // 8 x 65535 with last on 8th
      for (int i = 0; i < 7; i++) send(65535, 0);
      chk("g8_valid_early", dout_valid, 0);
      send(65535, 1);
      chk("g8_valid", dout_valid, 1);
      chk("g8_ready", din_ready, 0);
      chk("g8_dout", dout, 524280);
      chk("g8_len", dout_len, 8);
      chk("g8_ovf", dout_ovf, 0);
      take();
      chk("g8_released", dout_valid, 0);

      // 9 x 65535: positive overflow
      for (int i = 0; i < 8; i++) send(65535, 0);
      send(65535, 1);
      chk("pos_ovf", dout_ovf, 1);
      chk("pos_len", dout_len, 9);
`ifdef CASE_9_PROD_ACC_SAT_EN
      chk("pos_dout", dout, 524287);
`else
      chk("pos_dout", dout, -458761);
`endif
      take();

      // 9 x -65536: negative overflow
      for (int i = 0; i < 8; i++) send(-65536, 0);
      send(-65536, 1);
      chk("neg_ovf", dout_ovf, 1);
`ifdef CASE_9_PROD_ACC_SAT_EN
      chk("neg_dout", dout, -524288);
`else
      chk("neg_dout", dout, 458752);
`endif
      take();

      // 64 x 1 without last: forced flush
      for (int i = 0; i < 63; i++) send(1, 0);
      chk("max_early", dout_valid, 0);
      send(1, 0);
      chk("max_valid", dout_valid, 1);
      chk("max_dout", dout, 64);
      chk("max_len", dout_len, 64);
      chk("max_ovf", dout_ovf, 0);
      take();

      // 64 x 1 with last on 64th: one flush only
      for (int i = 0; i < 63; i++) send(1, 0);
      send(1, 1);
      chk("maxl_dout", dout, 64);
      chk("maxl_len", dout_len, 64);
      take();
      repeat (2) @(posedge ap_clk);
      #1 chk("maxl_single", dout_valid, 0);

      // backpressure: result held while an input waits
      send(5, 1);
      @(negedge ap_clk);
      din = 17'sd7; din_valid = 1'b1; din_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ap_clk);
         chk("bp_din_ready", din_ready, 0);
         chk("bp_dout", dout, 5);
         chk("bp_valid", dout_valid, 1);
      end
      dout_ready = 1'b1;
      @(posedge ap_clk); #1;
      dout_ready = 1'b0;
      chk("bp_after_hs_valid", dout_valid, 0);
      chk("bp_after_hs_ready", din_ready, 1);
      @(posedge ap_clk); #1;
      din_valid = 1'b0; din_last = 1'b0;
      chk("bp_pending_valid", dout_valid, 1);
      chk("bp_pending_dout", dout, 7);
      chk("bp_pending_len", dout_len, 1);
      take();

      // reset mid-group discards partial sum
      send(10, 0); send(20, 0); send(30, 0);
      @(negedge ap_clk); ap_rst = 1'b1;
      #1;
      chk("mrst_dout", dout, 0);
      chk("mrst_len", dout_len, 0);
      chk("mrst_ovf", dout_ovf, 0);
      chk("mrst_valid", dout_valid, 0);
      chk("mrst_ready", din_ready, 1);
      @(negedge ap_clk); ap_rst = 1'b0;
      send(1, 0);
      send(2, 1);
      chk("mrst_res_dout", dout, 3);
      chk("mrst_res_len", dout_len, 2);
      take();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/case_9_prod_acc.md
# case_9_prod_acc

Downstream consumer of the case_9 signed multiplier: accepts one 17-bit signed product per cycle over a valid/ready handshake and accumulates a group of products into a running sum. A group closes on `din_last` or when it reaches MAX_LEN terms. The sum is then narrowed to the output width and held on a registered valid/ready output until taken. It sits between the multiplier datapath and the result write-back stage of the case_9 dot-product kernel.

## Interface
Parameters:
- DIN_WIDTH, 17, signed product width (matches multiplier dout).
- DOUT_WIDTH, 20, signed result width.
- MAX_LEN, 64, maximum terms per group; forces a flush when reached.
- CNT_WIDTH, 7, width of the term counter, equal to clog2(MAX_LEN)+1.

Ports:
- ap_clk  in  1  single clock; all state on rising edge.
- ap_rst  in  1  reset, asynchronous and active-high.
- din  in  DIN_WIDTH  signed product.
- din_valid  in  1  product valid.
- din_last  in  1  final product of the group; qualified by din_valid.
- din_ready  out  1  block can accept a product.
- dout  out  DOUT_WIDTH  signed group sum.
- dout_len  out  CNT_WIDTH  number of terms in the group (1..MAX_LEN).
- dout_ovf  out  1  group sum exceeded the DOUT_WIDTH range.
- dout_valid  out  1  result valid.
- dout_ready  in  1  downstream accepts the result.

## Operation
- Internal accumulator is ACC_W = DIN_WIDTH + clog2(MAX_LEN) = 23 bits, sign-extended adds, so it never overflows.
- The FSM has two states.
- ACC state:
  - din_ready=1.
  - On a transfer (din_valid & din_ready): acc <= acc + sext(din), cnt <= cnt+1.
  - If din_last=1 or cnt+1==MAX_LEN: register the result (sum including this term, len=cnt+1), clear acc/cnt, go to HOLD.
  - If both conditions are true in the same cycle, exactly one flush occurs.
- HOLD state:
  - din_ready=0, dout_valid=1.
  - dout, dout_len and dout_ovf stay stable until dout_valid & dout_ready, then go to ACC.
  - An input presented during HOLD waits and is not dropped.
- Narrowing: dout_ovf=1 when the full sum is outside [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]. dout is then clamped or wrapped per Configuration.
- Reset (any time, including mid-group or during HOLD):
  - State ACC; acc, cnt = 0.
  - dout=0, dout_len=0, dout_ovf=0, dout_valid=0, din_ready=1 (one cycle after reset deassertion is not required; combinational from state).
  - A partial group is discarded.

## Timing
- Result latency: dout_valid rises the cycle after the closing input transfer.
- Throughput: one product per cycle within a group.
- Minimum one-cycle bubble per group for the HOLD handshake; no input is accepted in the cycle dout is consumed.
- din_ready is a function of state only, with no combinational path from dout_ready.
- dout_valid never drops without a handshake.
- Empty groups are not possible; the counter is never zero at flush.

## Configuration
- CASE_9_PROD_ACC_SAT_EN defined: out-of-range sums saturate to 2^(DOUT_WIDTH-1)-1 or -2^(DOUT_WIDTH-1).
- CASE_9_PROD_ACC_SAT_EN undefined: dout is the low DOUT_WIDTH bits of the sum (two's-complement wrap).
- dout_ovf behaves identically in both builds.

## Structure
- The shared package case_9_pkg holds:
  - the state enum (ST_ACC, ST_HOLD);
  - the ACC_W/CNT_WIDTH derivation function;
  - the saturation limit constants.
- One sub-module, case_9_prod_acc_narrow, is combinational: ACC_W sum in, DOUT_WIDTH value and ovf out, with the macro-selected clamp or wrap.
- Everything else is in the top module.

## Test plan
- 8 products of 65535, last on 8th → dout=524280, len=8, ovf=0, dout_valid one cycle after last.
- 9 products of 65535 → ovf=1; dout=524287 with SAT_EN, dout=-458761 without.
- 9 products of -65536 → ovf=1; dout=-524288 with SAT_EN, dout=458752 without.
- 64 products of 1, din_last never asserted → forced flush, dout=64, len=64. Also assert din_last on the 64th term → single flush only.
- Hold dout_ready=0 for 5 cycles with din_valid=1 → din_ready=0 and dout stable throughout; pending input accepted the cycle after the handshake, with no loss.
- Assert ap_rst after 3 of 5 terms (values 10,20,30), then send 1,2 with last → dout=3, len=2; all outputs 0 during reset.
